mac_array_stream: RTL and testbench

//  Parametrised NxN weight-stationary systolic multiply-accumulate engine computing y = x*Wt (vector x, matrix Wt).

---
 rtl/mac_array_stream.sv | 159 +++++++++++++++
 tb/tb_mac_array_stream.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_stream.sv
// Weight-stationary NxN multiply-accumulate engine computing y = x*Wt.
// Weight and data bytes load serially over a valid/ready port. The N results
// stream out over a valid/ready port that honours backpressure.
module mac_array_stream #(
    parameter int unsigned W      = 8,
    parameter int unsigned N      = 2,
    parameter int unsigned ACC_W  = 20,
    parameter bit          SIGNED = 1'b0,
    parameter bit          SAT    = 1'b0,
    parameter int unsigned DBG_A  = $clog2(N*N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_mode_i,
    input  logic             in_rst_addr_i,
    input  logic [W-1:0]     in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W-1:0]     out_data_o,
    output logic             out_last_o,
    output logic             busy_o,
    input  logic [DBG_A-1:0] dbg_addr_i,
    output logic [W-1:0]     dbg_data_o
);

    localparam int unsigned NN = N * N;
    localparam int unsigned XA = $clog2(N);
    localparam int unsigned KW = $clog2(2 * N);

    typedef enum logic [1:0] {IDLE, COMPUTE, STREAM} state_t;

    state_t           state;
    logic [W-1:0]     wt  [NN];
    logic [W-1:0]     xv  [N];
    logic [ACC_W-1:0] acc [N];
    logic [DBG_A-1:0] widx;
    logic [XA-1:0]    xidx;
    logic [XA-1:0]    ocnt;
    logic [KW-1:0]    kcnt;

    logic             accept;
    logic [DBG_A-1:0] w_at;
    logic [XA-1:0]    x_at;
    logic [DBG_A-1:0] w_next;

    // Widen an operand to accumulator width, sign-extending in signed mode.
    function automatic logic [ACC_W-1:0] ext(input logic [W-1:0] v);
        if (SIGNED) return {{(ACC_W-W){v[W-1]}}, v};
        else        return {{(ACC_W-W){1'b0}}, v};
    endfunction

    // Reduce an accumulator to W bits, by truncation or by clamping.
    function automatic logic [W-1:0] fmt(input logic [ACC_W-1:0] a);
        logic [W-1:0] r;
        r = a[W-1:0];
        if (SAT) begin
            if (SIGNED) begin
                if (!((&a[ACC_W-1:W-1]) || !(|a[ACC_W-1:W-1])))
                    r = a[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end else if (|a[ACC_W-1:W]) begin
                r = '1;
            end
        end
        return r;
    endfunction

    // Resolve the store index of an incoming byte. An address restart forces it to 0.
    assign accept = in_valid_i & in_ready_o;
    assign w_at   = in_rst_addr_i ? '0 : widx;
    assign x_at   = in_rst_addr_i ? '0 : xidx;
    assign w_next = (w_at == DBG_A'(NN - 1)) ? '0 : w_at + DBG_A'(1);

    // Combinational debug read of the weight store
    assign dbg_data_o = (int'(dbg_addr_i) < int'(NN)) ? wt[dbg_addr_i] : '0;

    // Control FSM, operand storage, skewed accumulation and the result stream
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            busy_o      <= 1'b0;
            widx        <= '0;
            xidx        <= '0;
            ocnt        <= '0;
            kcnt        <= '0;
            for (int i = 0; i < int'(NN); i++) wt[i] <= '0;
            for (int i = 0; i < int'(N); i++) begin
                xv[i]  <= '0;
                acc[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_mode_i) begin
                            wt[w_at] <= in_data_i;
                            widx     <= w_next;
                            xidx     <= '0;
                        end else begin
                            xv[x_at] <= in_data_i;
                            if (x_at == XA'(N - 1)) begin
                                xidx       <= '0;
                                state      <= COMPUTE;
                                in_ready_o <= 1'b0;
                                busy_o     <= 1'b1;
                                kcnt       <= '0;
                                for (int c = 0; c < int'(N); c++) acc[c] <= '0;
                            end else begin
                                xidx <= x_at + XA'(1);
                            end
                        end
                    end else if (in_rst_addr_i) begin
                        widx <= '0;
                        xidx <= '0;
                    end
                end
                COMPUTE: begin
                    // Row k takes its x element on cycle k. The extra cycles drain the array skew.
                    if (kcnt < KW'(N)) begin
                        for (int c = 0; c < int'(N); c++)
                            acc[c] <= acc[c] + ext(xv[XA'(kcnt)])
                                     * ext(wt[DBG_A'(int'(kcnt) * int'(N) + c)]);
                    end
                    if (kcnt == KW'(2 * N - 2)) begin
                        state       <= STREAM;
                        out_valid_o <= 1'b1;
                        out_data_o  <= fmt(acc[0]);
                        out_last_o  <= 1'b0;
                        ocnt        <= '0;
                    end else begin
                        kcnt <= kcnt + KW'(1);
                    end
                end
                STREAM: begin
                    if (out_ready_i) begin
                        if (ocnt == XA'(N - 1)) begin
                            state       <= IDLE;
                            out_valid_o <= 1'b0;
                            out_last_o  <= 1'b0;
                            in_ready_o  <= 1'b1;
                            busy_o      <= 1'b0;
                        end else begin
                            ocnt       <= ocnt + XA'(1);
                            out_data_o <= fmt(acc[ocnt + XA'(1)]);
                            out_last_o <= ((ocnt + XA'(1)) == XA'(N - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_array_stream.sv
// Directed bench for mac_array_stream. Three N=2 variants (truncate, unsigned
// saturate, signed saturate) share one stimulus bus. A separate N=4 instance
// is selected through sel4.
module tb_mac_array_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_mode, in_rst_addr, sel4, out_ready;
    logic [7:0] in_data;
    logic [3:0] dbg_addr;
    logic       v_g, v_d, ra_g, ra_d;

    assign v_g  = in_valid & ~sel4;
    assign v_d  = in_valid & sel4;
    assign ra_g = in_rst_addr & ~sel4;
    assign ra_d = in_rst_addr & sel4;

    logic rdy_a, ov_a, last_a, busy_a, rdy_b, ov_b, last_b, busy_b;
    logic rdy_c, ov_c, last_c, busy_c, rdy_d, ov_d, last_d, busy_d;
    logic [7:0] od_a, od_b, od_c, od_d, dbg_a, dbg_b, dbg_c, dbg_d;

    mac_array_stream #(.W(8), .N(2), .ACC_W(20), .SIGNED(1'b0), .SAT(1'b0), .DBG_A(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid_i(v_g), .in_ready_o(rdy_a), .in_mode_i(in_mode),
        .in_rst_addr_i(ra_g), .in_data_i(in_data), .out_valid_o(ov_a), .out_ready_i(out_ready),
        .out_data_o(od_a), .out_last_o(last_a), .busy_o(busy_a), .dbg_addr_i(dbg_addr[1:0]),
        .dbg_data_o(dbg_a));
    mac_array_stream #(.W(8), .N(2), .ACC_W(20), .SIGNED(1'b0), .SAT(1'b1), .DBG_A(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid_i(v_g), .in_ready_o(rdy_b), .in_mode_i(in_mode),
        .in_rst_addr_i(ra_g), .in_data_i(in_data), .out_valid_o(ov_b), .out_ready_i(out_ready),
        .out_data_o(od_b), .out_last_o(last_b), .busy_o(busy_b), .dbg_addr_i(dbg_addr[1:0]),
        .dbg_data_o(dbg_b));
    mac_array_stream #(.W(8), .N(2), .ACC_W(20), .SIGNED(1'b1), .SAT(1'b1), .DBG_A(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid_i(v_g), .in_ready_o(rdy_c), .in_mode_i(in_mode),
        .in_rst_addr_i(ra_g), .in_data_i(in_data), .out_valid_o(ov_c), .out_ready_i(out_ready),
        .out_data_o(od_c), .out_last_o(last_c), .busy_o(busy_c), .dbg_addr_i(dbg_addr[1:0]),
        .dbg_data_o(dbg_c));
    mac_array_stream #(.W(8), .N(4), .ACC_W(20), .SIGNED(1'b0), .SAT(1'b0), .DBG_A(4)) dut_d (
        .clk(clk), .rst(rst), .in_valid_i(v_d), .in_ready_o(rdy_d), .in_mode_i(in_mode),
        .in_rst_addr_i(ra_d), .in_data_i(in_data), .out_valid_o(ov_d), .out_ready_i(out_ready),
        .out_data_o(od_d), .out_last_o(last_d), .busy_o(busy_d), .dbg_addr_i(dbg_addr),
        .dbg_data_o(dbg_d));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One accepted byte. Called and returns 1 time unit after a rising edge.
    task automatic send(input logic four, input logic mode, input logic [7:0] data, input logic ra);
        sel4 = four; in_mode = mode; in_data = data; in_rst_addr = ra; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_rst_addr = 1'b0;
    endtask

    task automatic load_w2(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(1'b0, 1'b1, w[8*i +: 8], 1'b0);
    endtask

    task automatic wait_valid(input logic four, output int cyc);
        cyc = 0;
        while (!(four ? ov_d : ov_a) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!(four ? ov_d : ov_a)) check("valid_timeout", 32'd0, 32'd1);
    endtask

    // Drain the two N=2 results. Each expectation is packed as {y1, y0}.
    task automatic collect2(input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ec);
        int cyc;
        wait_valid(1'b0, cyc);
        for (int i = 0; i < 2; i++) begin
            check("y_trunc", od_a, ea[8*i +: 8]);
            check("y_usat", od_b, eb[8*i +: 8]);
            check("y_ssat", od_c, ec[8*i +: 8]);
            check("last2", last_a, (i == 1));
            @(posedge clk); #1;
        end
        check("end_valid2", ov_a, 32'd0);
        check("end_ready2", rdy_a, 32'd1);
    endtask

    task automatic collect4(input logic [31:0] e);
        int cyc;
        wait_valid(1'b1, cyc);
        for (int i = 0; i < 4; i++) begin
            check("y4", od_d, e[8*i +: 8]);
            check("last4", last_d, (i == 3));
            @(posedge clk); #1;
        end
        check("end_valid4", ov_d, 32'd0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_rst_addr = 1'b0; sel4 = 1'b0;
        in_data = '0; out_ready = 1'b1; dbg_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_ready", rdy_a, 32'd1);
        check("rst_valid", ov_a, 32'd0);
        check("rst_data", od_a, 32'd0);
        check("rst_last", last_a, 32'd0);
        check("rst_busy", busy_a, 32'd0);

        // Basic product, busy flag and latency
        load_w2(32'h04030201);
        send(1'b0, 1'b0, 8'd5, 1'b0);
        send(1'b0, 1'b0, 8'd6, 1'b0);
        check("busy_compute", busy_a, 32'd1);
        check("ready_compute", rdy_a, 32'd0);
        wait_valid(1'b0, cyc);
        check("latency2", cyc, 32'd3);
        collect2({8'd34, 8'd23}, {8'd34, 8'd23}, {8'd34, 8'd23});
        dbg_addr = 4'd3; #1;
        check("dbg_w11", dbg_a, 32'd4);

        // Overflow: truncation versus saturation
        load_w2(32'hFFFFFFFF);
        send(1'b0, 1'b0, 8'hFF, 1'b0);
        send(1'b0, 1'b0, 8'hFF, 1'b0);
        collect2({8'h02, 8'h02}, {8'hFF, 8'hFF}, {8'h02, 8'h02});

        // Signed arithmetic and signed clamp
        load_w2(32'hFF0000FF);
        send(1'b0, 1'b0, 8'h02, 1'b0);
        send(1'b0, 1'b0, 8'h03, 1'b0);
        collect2({8'hFD, 8'hFE}, {8'hFF, 8'hFF}, {8'hFD, 8'hFE});
        load_w2(32'h7F7F7F7F);
        send(1'b0, 1'b0, 8'h7F, 1'b0);
        send(1'b0, 1'b0, 8'h7F, 1'b0);
        collect2({8'h02, 8'h02}, {8'hFF, 8'hFF}, {8'h7F, 8'h7F});

        // Backpressure at the first beat
        load_w2(32'h04030201);
        out_ready = 1'b0;
        send(1'b0, 1'b0, 8'd5, 1'b0);
        send(1'b0, 1'b0, 8'd6, 1'b0);
        wait_valid(1'b0, cyc);
        for (int k = 0; k < 4; k++) begin
            check("stall_data", od_a, 32'd23);
            check("stall_last", last_a, 32'd0);
            check("stall_ready", rdy_a, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        collect2({8'd34, 8'd23}, {8'd34, 8'd23}, {8'd34, 8'd23});

        // A partial vector is discarded by a weight byte
        send(1'b0, 1'b0, 8'd5, 1'b0);
        send(1'b0, 1'b1, 8'd7, 1'b0);
        send(1'b0, 1'b0, 8'd1, 1'b0);
        send(1'b0, 1'b0, 8'd2, 1'b0);
        collect2({8'd10, 8'd13}, {8'd10, 8'd13}, {8'd10, 8'd13});
        dbg_addr = 4'd0; #1;
        check("dbg_discard", dbg_a, 32'd7);

        // Idle address restart, then a restart on the 3rd weight byte
        in_rst_addr = 1'b1; sel4 = 1'b0;
        @(posedge clk); #1 in_rst_addr = 1'b0;
        send(1'b0, 1'b1, 8'h11, 1'b0);
        send(1'b0, 1'b1, 8'h22, 1'b0);
        send(1'b0, 1'b1, 8'h33, 1'b1);
        send(1'b0, 1'b1, 8'h44, 1'b0);
        dbg_addr = 4'd0; #1 check("dbg_ra0", dbg_a, 32'h33);
        dbg_addr = 4'd1; #1 check("dbg_ra1", dbg_a, 32'h44);
        dbg_addr = 4'd2; #1 check("dbg_ra2", dbg_a, 32'h03);

        // Reset in the middle of STREAM
        dbg_addr = 4'd0;
        out_ready = 1'b0;
        send(1'b0, 1'b0, 8'd1, 1'b0);
        send(1'b0, 1'b0, 8'd1, 1'b0);
        wait_valid(1'b0, cyc);
        check("pre_rst_data", od_a, 32'd54);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", ov_a, 32'd0);
        check("midrst_dbg", dbg_a, 32'd0);
        check("midrst_ready", rdy_a, 32'd1);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("midrst_quiet", ov_a, 32'd0);

        // N=4 identity weights, then reuse them with a new vector
        for (int i = 0; i < 16; i++)
            send(1'b1, 1'b1, ((i % 5) == 0) ? 8'd1 : 8'd0, 1'b0);
        send(1'b1, 1'b0, 8'd9, 1'b0);
        send(1'b1, 1'b0, 8'd8, 1'b0);
        send(1'b1, 1'b0, 8'd7, 1'b0);
        send(1'b1, 1'b0, 8'd6, 1'b0);
        wait_valid(1'b1, cyc);
        check("latency4", cyc, 32'd7);
        collect4({8'd6, 8'd7, 8'd8, 8'd9});
        send(1'b1, 1'b0, 8'd1, 1'b0);
        send(1'b1, 1'b0, 8'd2, 1'b0);
        send(1'b1, 1'b0, 8'd3, 1'b0);
        send(1'b1, 1'b0, 8'd4, 1'b0);
        collect4({8'd4, 8'd3, 8'd2, 8'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
